// File: rtl/cpc_pi_mailbox.sv
// CPC Z80 I/O-port <-> Raspberry Pi req/ack mailbox with a byte FIFO in each direction.
// Everything runs on the CPC clock; the asynchronous Pi controls are synchronised in.
`timescale 1ns/1ps

module cpc_pi_mailbox #(
    parameter logic [7:0] ADDR_HI     = 8'hFD,
    parameter int         DEPTH_LOG2  = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic        IOREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic        M1_B,
    input  logic        pi_req,
    input  logic        pi_rnw,
    input  logic        pi_sel,
    input  logic [7:0]  pi_data_in,
    output logic [7:0]  pi_data_out,
    output logic        pi_ack,
    output logic        pi_irq
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam int                    CW       = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_ACK, ST_WAIT} pi_state_t;

    logic hit, wr_act, rd_act, wr_act_q, rd_act_q, rd_sel_q;
    logic cpc_wr_start, cpc_rd_end;

    assign hit          = !IOREQ_B && M1_B && (A[15:8] == ADDR_HI) && (A[7:1] == 7'd0);
    assign wr_act       = hit && !WR_B;
    assign rd_act       = hit && !RD_B;
    assign cpc_wr_start = wr_act && !wr_act_q;
    assign cpc_rd_end   = !rd_act && rd_act_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_act_q <= 1'b0;
            rd_act_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            wr_act_q <= wr_act;
            rd_act_q <= rd_act;
            if (rd_act) rd_sel_q <= A[0];
        end
    end

    // Pi controls: req resets to all-ones so a req held across reset is not a new edge.
    logic [SYNC_STAGES-1:0] req_sync, rnw_sync, sel_sync;
    logic req_s, rnw_s, sel_s, req_prev;

    assign req_s = req_sync[SYNC_STAGES-1];
    assign rnw_s = rnw_sync[SYNC_STAGES-1];
    assign sel_s = sel_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_sync <= '1;
            rnw_sync <= '0;
            sel_sync <= '0;
            req_prev <= 1'b1;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], pi_req};
            rnw_sync <= {rnw_sync[SYNC_STAGES-2:0], pi_rnw};
            sel_sync <= {sel_sync[SYNC_STAGES-2:0], pi_sel};
            req_prev <= req_s;
        end
    end

    pi_state_t state;
    logic      pi_exec;
    assign pi_exec = (state == ST_EXEC);

    logic [7:0]            h2p_mem [DEPTH];
    logic [7:0]            p2h_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] h2p_wr, h2p_rd, p2h_wr, p2h_rd;
    logic [CW-1:0]         h2p_cnt, p2h_cnt;
    logic                  h2p_full, h2p_empty, p2h_full, p2h_empty;
    logic                  h2p_push, h2p_pop, p2h_push, p2h_pop;
    logic                  h2p_push_req, p2h_push_req, ovf;
    logic [7:0]            h2p_head, p2h_head, cpc_status, pi_status;

    assign h2p_full     = (h2p_cnt == CNT_FULL);
    assign h2p_empty    = (h2p_cnt == '0);
    assign p2h_full     = (p2h_cnt == CNT_FULL);
    assign p2h_empty    = (p2h_cnt == '0);
    assign h2p_push_req = cpc_wr_start && !A[0];
    assign p2h_push_req = pi_exec && !rnw_s && !sel_s;
    assign h2p_push     = h2p_push_req && !h2p_full;
    assign h2p_pop      = pi_exec && rnw_s && !sel_s && !h2p_empty;
    assign p2h_push     = p2h_push_req && !p2h_full;
    assign p2h_pop      = cpc_rd_end && !rd_sel_q && !p2h_empty;
    assign h2p_head     = h2p_empty ? 8'hFF : h2p_mem[h2p_rd];
    assign p2h_head     = p2h_empty ? 8'hFF : p2h_mem[p2h_rd];
    assign cpc_status   = {ovf, 5'b0, !h2p_full, !p2h_empty};
    assign pi_status    = {ovf, 5'b0, !p2h_full, !h2p_empty};

    // NOTE: FIFO storage is not reset; the counts alone say which entries are valid.
    always_ff @(posedge CLK) begin
        if (h2p_push) h2p_mem[h2p_wr] <= D_in;
        if (p2h_push) p2h_mem[p2h_wr] <= pi_data_in;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            h2p_wr  <= '0;
            h2p_rd  <= '0;
            h2p_cnt <= '0;
            p2h_wr  <= '0;
            p2h_rd  <= '0;
            p2h_cnt <= '0;
        end else begin
            if (h2p_push) h2p_wr <= h2p_wr + PTR_ONE;
            if (h2p_pop)  h2p_rd <= h2p_rd + PTR_ONE;
            if (h2p_push && !h2p_pop)      h2p_cnt <= h2p_cnt + CNT_ONE;
            else if (!h2p_push && h2p_pop) h2p_cnt <= h2p_cnt - CNT_ONE;
            if (p2h_push) p2h_wr <= p2h_wr + PTR_ONE;
            if (p2h_pop)  p2h_rd <= p2h_rd + PTR_ONE;
            if (p2h_push && !p2h_pop)      p2h_cnt <= p2h_cnt + CNT_ONE;
            else if (!p2h_push && p2h_pop) p2h_cnt <= p2h_cnt - CNT_ONE;
        end
    end

    // Overflow wins over a same-cycle status-read clear so no drop goes unreported.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovf    <= 1'b0;
            pi_irq <= 1'b0;
        end else begin
            if ((h2p_push_req && h2p_full) || (p2h_push_req && p2h_full)) ovf <= 1'b1;
            else if (cpc_rd_end && rd_sel_q)                              ovf <= 1'b0;
            pi_irq <= !h2p_empty;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            pi_ack      <= 1'b0;
            pi_data_out <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: if (req_s && !req_prev) state <= ST_EXEC;
                ST_EXEC: begin
                    if (rnw_s) pi_data_out <= sel_s ? pi_status : h2p_head;
                    pi_ack <= 1'b1;
                    state  <= ST_ACK;
                end
                ST_ACK: if (!req_s) begin
                    pi_ack <= 1'b0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign D_oe  = rd_act;
    assign D_out = A[0] ? cpc_status : p2h_head;

endmodule

// File: tb/tb_cpc_pi_mailbox.sv
// Bench for cpc_pi_mailbox: queue-based reference model checked every cycle,
// plus directed CPC/Pi transactions with hand-computed expectations.
`timescale 1ns/1ps

module tb_cpc_pi_mailbox;

    localparam int DEPTH   = 16;
    localparam int SYNC    = 2;
    localparam int ACK_LAT = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D_in = 8'h00;
    logic [7:0]  D_out;
    logic        D_oe;
    logic        IOREQ_B = 1'b1, RD_B = 1'b1, WR_B = 1'b1, M1_B = 1'b1;
    logic        pi_req = 1'b0, pi_rnw = 1'b0, pi_sel = 1'b0;
    logic [7:0]  pi_data_in = 8'h00;
    logic [7:0]  pi_data_out;
    logic        pi_ack, pi_irq;

    always #5 CLK = ~CLK;

    cpc_pi_mailbox dut (
        .CLK(CLK), .RESET(RESET), .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
        .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B),
        .pi_req(pi_req), .pi_rnw(pi_rnw), .pi_sel(pi_sel), .pi_data_in(pi_data_in),
        .pi_data_out(pi_data_out), .pi_ack(pi_ack), .pi_irq(pi_irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: two byte queues, a sticky flag and a Pi transaction phase.
    logic [7:0] h2p_q[$];
    logic [7:0] p2h_q[$];
    logic       m_live = 1'b0;
    logic       m_ovf, m_ack, m_irq, m_prev_wr, m_prev_rd, m_rd_sel, m_prev_req;
    logic [7:0] m_pdo;
    int         m_phase;
    logic       req_hist[SYNC];
    logic       rnw_hist[SYNC];
    logic       sel_hist[SYNC];

    always @(posedge CLK) begin
        logic seen_req, seen_rnw, seen_sel, hitv, wra, rda;
        logic cpc_push, rd_end, pi_pop, pi_push, hf, he, pf, pe, ovf_set;
        seen_req = req_hist[SYNC-1];
        seen_rnw = rnw_hist[SYNC-1];
        seen_sel = sel_hist[SYNC-1];
        for (int i = SYNC-1; i > 0; i--) begin
            req_hist[i] = req_hist[i-1];
            rnw_hist[i] = rnw_hist[i-1];
            sel_hist[i] = sel_hist[i-1];
        end
        req_hist[0] = pi_req;
        rnw_hist[0] = pi_rnw;
        sel_hist[0] = pi_sel;
        if (RESET) begin
            h2p_q.delete();
            p2h_q.delete();
            m_ovf = 0; m_ack = 0; m_irq = 0; m_pdo = 8'h00; m_phase = 0;
            m_prev_wr = 0; m_prev_rd = 0; m_rd_sel = 0; m_prev_req = 1;
            m_live = 1'b1;
        end else begin
            hf = (h2p_q.size() == DEPTH);
            he = (h2p_q.size() == 0);
            pf = (p2h_q.size() == DEPTH);
            pe = (p2h_q.size() == 0);
            hitv = !IOREQ_B && M1_B && (A[15:8] == 8'hFD) && (A[7:1] == 7'd0);
            wra = hitv && !WR_B;
            rda = hitv && !RD_B;
            cpc_push = wra && !m_prev_wr && !A[0];
            rd_end   = !rda && m_prev_rd;
            pi_pop   = (m_phase == 1) && seen_rnw && !seen_sel;
            pi_push  = (m_phase == 1) && !seen_rnw && !seen_sel;
            if (m_phase == 1 && seen_rnw)
                m_pdo = seen_sel ? {m_ovf, 5'b0, !pf, !he} : (he ? 8'hFF : h2p_q[0]);
            ovf_set = (cpc_push && hf) || (pi_push && pf);
            if (pi_pop && !he) void'(h2p_q.pop_front());
            if (cpc_push && !hf) h2p_q.push_back(D_in);
            if (rd_end && !m_rd_sel && !pe) void'(p2h_q.pop_front());
            if (pi_push && !pf) p2h_q.push_back(pi_data_in);
            if (rd_end && m_rd_sel) m_ovf = 0;
            if (ovf_set) m_ovf = 1;
            m_prev_wr = wra;
            m_prev_rd = rda;
            if (rda) m_rd_sel = A[0];
            case (m_phase)
                0: if (seen_req && !m_prev_req) m_phase = 1;
                1: begin m_phase = 2; m_ack = 1; end
                2: if (!seen_req) begin m_phase = 3; m_ack = 0; end
                default: m_phase = 0;
            endcase
            m_prev_req = seen_req;
            m_irq = !he;
        end
    end

    always @(posedge CLK) begin
        logic [7:0] exp_dout;
        logic       exp_oe;
        #1;
        if (m_live) begin
            exp_oe = !IOREQ_B && M1_B && (A[15:8] == 8'hFD) && (A[7:1] == 7'd0) && !RD_B;
            if (A[0]) exp_dout = {m_ovf, 5'b0, h2p_q.size() != DEPTH, p2h_q.size() != 0};
            else      exp_dout = (p2h_q.size() == 0) ? 8'hFF : p2h_q[0];
            check("model_pi_ack", pi_ack, m_ack);
            check("model_pi_data_out", pi_data_out, m_pdo);
            check("model_pi_irq", pi_irq, m_irq);
            check("model_D_oe", D_oe, exp_oe);
            check("model_D_out", D_out, exp_dout);
        end
    end

    task automatic cpc_write(input logic [15:0] addr, input logic [7:0] data, input logic m1,
                             output logic [1:0] irq_seen);
        @(negedge CLK);
        A = addr; D_in = data; M1_B = m1; IOREQ_B = 1'b0; WR_B = 1'b0;
        @(negedge CLK); irq_seen[0] = pi_irq;
        @(negedge CLK); irq_seen[1] = pi_irq;
        @(negedge CLK);
        WR_B = 1'b1; IOREQ_B = 1'b1; M1_B = 1'b1;
        @(negedge CLK);
    endtask

    task automatic cpc_read(input logic [15:0] addr, input logic [7:0] expected, input string name);
        @(negedge CLK);
        A = addr; IOREQ_B = 1'b0; RD_B = 1'b0;
        @(negedge CLK);
        check({name, "_oe_on"}, D_oe, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge CLK);
            check(name, D_out, expected);
        end
        RD_B = 1'b1; IOREQ_B = 1'b1;
        @(negedge CLK);
        check({name, "_oe_off"}, D_oe, 1'b0);
    endtask

    task automatic pi_xfer(input logic rnw, input logic sel, input logic [7:0] wdata,
                           input logic [7:0] expected, input string name, output logic [1:0] irq_pair);
        int n;
        @(negedge CLK);
        pi_rnw = rnw; pi_sel = sel; pi_data_in = wdata; pi_req = 1'b1;
        n = 0;
        irq_pair = 2'b00;
        while (n < 20 && !pi_ack) begin
            @(negedge CLK);
            n++;
        end
        irq_pair[0] = pi_irq;
        check({name, "_ack_latency"}, n, ACK_LAT);
        if (rnw) check(name, pi_data_out, expected);
        @(negedge CLK);
        irq_pair[1] = pi_irq;
        pi_req = 1'b0;
        n = 0;
        while (n < 20 && pi_ack) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_ack_release"}, pi_ack, 1'b0);
        @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] irqp, irqw;
        logic [7:0] v;

        repeat (4) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("reset_pi_ack", pi_ack, 1'b0);
        check("reset_pi_data_out", pi_data_out, 8'h00);
        check("reset_pi_irq", pi_irq, 1'b0);
        repeat (3) @(negedge CLK);

        // Interrupt-acknowledge cycles never hit the ports.
        A = 16'hFD00; IOREQ_B = 1'b0; RD_B = 1'b0; M1_B = 1'b0;
        @(negedge CLK);
        check("m1_no_oe", D_oe, 1'b0);
        IOREQ_B = 1'b1; RD_B = 1'b1; M1_B = 1'b1;
        cpc_write(16'hFD00, 8'h77, 1'b0, irqp);
        cpc_read(16'hFD01, 8'h02, "reset_status");
        cpc_read(16'hFD00, 8'hFF, "empty_data");

        cpc_write(16'hFD00, 8'hA5, 1'b1, irqp);
        check("irq_rise_after_push", irqp, 2'b10);
        pi_xfer(1'b1, 1'b0, 8'h00, 8'hA5, "pi_read_a5", irqp);
        check("irq_fall_after_pop", irqp, 2'b01);

        pi_xfer(1'b0, 1'b0, 8'h11, 8'h00, "pi_wr11", irqp);
        pi_xfer(1'b0, 1'b0, 8'h22, 8'h00, "pi_wr22", irqp);
        pi_xfer(1'b0, 1'b0, 8'h33, 8'h00, "pi_wr33", irqp);
        pi_xfer(1'b1, 1'b1, 8'h00, 8'h02, "pi_status", irqp);
        cpc_read(16'hFD01, 8'h03, "status_3");
        cpc_read(16'hFD00, 8'h11, "p2h_rd11");
        cpc_read(16'hFD00, 8'h22, "p2h_rd22");
        cpc_read(16'hFD00, 8'h33, "p2h_rd33");
        cpc_read(16'hFD00, 8'hFF, "p2h_rd_empty");

        pi_xfer(1'b0, 1'b0, 8'hEE, 8'h00, "pi_wrEE", irqp);
        for (int i = 0; i < 17; i++) begin
            v = 8'h40 + 8'(i);
            cpc_write(16'hFD00, v, 1'b1, irqp);
        end
        cpc_read(16'hFD01, 8'h81, "ovf_status");
        cpc_read(16'hFD01, 8'h01, "ovf_cleared");
        for (int i = 0; i < 16; i++) begin
            v = 8'h40 + 8'(i);
            pi_xfer(1'b1, 1'b0, 8'h00, v, "fill_read", irqp);
        end
        pi_xfer(1'b1, 1'b0, 8'h00, 8'hFF, "fill_read_17", irqp);
        cpc_read(16'hFD00, 8'hEE, "p2h_rdEE");
        cpc_read(16'hFD01, 8'h02, "status_idle");

        // Same-cycle CPC push and Pi pop with three entries held, across pointer wrap.
        cpc_write(16'hFD00, 8'h90, 1'b1, irqp);
        cpc_write(16'hFD00, 8'h91, 1'b1, irqp);
        cpc_write(16'hFD00, 8'h92, 1'b1, irqp);
        for (int k = 0; k < 20; k++) begin
            fork
                pi_xfer(1'b1, 1'b0, 8'h00, 8'h90 + 8'(k), "wrap_read", irqp);
                begin
                    repeat (3) @(negedge CLK);
                    cpc_write(16'hFD00, 8'h93 + 8'(k), 1'b1, irqw);
                end
            join
        end
        pi_xfer(1'b1, 1'b0, 8'h00, 8'hA4, "drain_a4", irqp);
        pi_xfer(1'b1, 1'b0, 8'h00, 8'hA5, "drain_a5", irqp);
        pi_xfer(1'b1, 1'b0, 8'h00, 8'hA6, "drain_a6", irqp);
        pi_xfer(1'b1, 1'b0, 8'h00, 8'hFF, "drain_empty", irqp);

        // Reset while a Pi transaction is in ACK with req still high.
        @(negedge CLK);
        pi_rnw = 1'b1; pi_sel = 1'b1; pi_req = 1'b1;
        repeat (4) @(negedge CLK);
        check("pre_reset_ack", pi_ack, 1'b1);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (8) @(negedge CLK);
        check("held_req_ack_low", pi_ack, 1'b0);
        check("held_req_pdo_reset", pi_data_out, 8'h00);
        pi_req = 1'b0;
        repeat (4) @(negedge CLK);
        pi_xfer(1'b1, 1'b1, 8'h00, 8'h02, "post_reset_status", irqp);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
